// File: rtl/vga_pkg.sv
// Shared constants for the VGA text-cursor controller: screen geometry,
// coordinate widths and cursor command codes.
package vga_pkg;

    localparam int COLS_DEF         = 80;
    localparam int ROWS_DEF         = 25;
    localparam int ADDR_W_DEF       = 11;
    localparam int BLINK_FRAMES_DEF = 16;

    localparam int COL_W = 7;
    localparam int ROW_W = 5;
    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_NOP     = 3'd0;
    localparam logic [CMD_W-1:0] CMD_SET     = 3'd1;
    localparam logic [CMD_W-1:0] CMD_RIGHT   = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT    = 3'd3;
    localparam logic [CMD_W-1:0] CMD_NEWLINE = 3'd4;
    localparam logic [CMD_W-1:0] CMD_CR      = 3'd5;
    localparam logic [CMD_W-1:0] CMD_HOME    = 3'd6;

endpackage

// File: rtl/vga_cursor_blink.sv
// Frame-counted cursor blink phase. A clear keeps the cursor solid while the
// host is moving it; the enable only masks the output, never the counter.
module vga_cursor_blink
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_start,
    input  logic i_clr,
    input  logic i_en,
    output logic o_blink_on
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // Clear has priority over a frame pulse landing on the same edge.
        if (i_clr) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (i_frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign o_blink_on = phase_q & i_en;

endmodule

// File: rtl/vga_cursor_pos_ctrl.sv
// Text cursor position controller: applies host cursor commands to col/row,
// then spends one cycle forming the linear address for the compare stage.
module vga_cursor_pos_ctrl
    import vga_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [COL_W-1:0]  i_col,
    input  logic [ROW_W-1:0]  i_row,
    input  logic              i_frame_start,
    input  logic              i_cur_en,
    output logic [ADDR_W-1:0] o_cur_pos_addr,
    output logic [COL_W-1:0]  o_cur_col,
    output logic [ROW_W-1:0]  o_cur_row,
    output logic              o_blink_on,
    output logic              o_scroll_req
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    logic [0:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              scroll_q, scroll_d;

    logic              accept;
    logic              blink_clr;
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] calc_addr;

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign blink_clr   = accept && (i_cmd >= CMD_SET) && (i_cmd <= CMD_HOME);

    assign row_ext = ADDR_W'(row_q);

    // 80 columns decomposes into 64 + 16, so the address needs no multiplier.
    generate
        if (COLS == 80) begin : g_addr_shift
            assign calc_addr = (row_ext << 6) + (row_ext << 4) + ADDR_W'(col_q);
        end else begin : g_addr_mul
            assign calc_addr = row_ext * ADDR_W'(COLS) + ADDR_W'(col_q);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        scroll_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CALC;
                    case (i_cmd)
                        CMD_SET: begin
                            col_d = (i_col > COL_MAX) ? COL_MAX : i_col;
                            row_d = (i_row > ROW_MAX) ? ROW_MAX : i_row;
                        end
                        CMD_RIGHT: begin
                            if (col_q == COL_MAX) begin
                                col_d = '0;
                                if (row_q == ROW_MAX) scroll_d = 1'b1;
                                else                  row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                        CMD_LEFT: begin
                            // Top-left corner is a hard stop: no wrap, no scroll.
                            if (col_q == '0) begin
                                if (row_q != '0) begin
                                    col_d = COL_MAX;
                                    row_d = row_q - ROW_W'(1);
                                end
                            end else begin
                                col_d = col_q - COL_W'(1);
                            end
                        end
                        CMD_NEWLINE: begin
                            col_d = '0;
                            if (row_q == ROW_MAX) scroll_d = 1'b1;
                            else                  row_d = row_q + ROW_W'(1);
                        end
                        CMD_CR: begin
                            col_d = '0;
                        end
                        CMD_HOME: begin
                            col_d = '0;
                            row_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                addr_d  = calc_addr;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            scroll_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            scroll_q <= scroll_d;
        end
    end

    vga_cursor_blink #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_clr         (blink_clr),
        .i_en          (i_cur_en),
        .o_blink_on    (o_blink_on)
    );

    assign o_cur_pos_addr = addr_q;
    assign o_cur_col      = col_q;
    assign o_cur_row      = row_q;
    assign o_scroll_req   = scroll_q;

endmodule
